// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci request scheduler: FSM state
// encoding and the default operand width / requester count.
package fib_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int FIB_WIDTH = 8;
   localparam int FIB_NREQ  = 4;

endpackage : fib_pkg

// File: rtl/fib_core.sv
// Iterative Fibonacci engine. Holds the pair (a, b) = (F(k), F(k+1)) and
// a remaining step count. Overflow is tracked per element so that the
// flag reported alongside a reflects only whether F(k) itself wrapped.
module fib_core
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] n,
   input  logic             step,
   output logic             done,
   output logic [WIDTH-1:0] fib,
   output logic             ovf
);

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] cnt_r;
   logic             ovf_a_r;
   logic             ovf_b_r;
   logic [WIDTH:0]   sum_s;

   // Widened sum so the carry-out of a+b is visible for overflow tracking.
   always_comb begin
      sum_s = {1'b0, a_r} + {1'b0, b_r};
   end

   // Engine state: load seeds (0, 1, n); each step advances one Fibonacci index.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         cnt_r   <= '0;
         ovf_a_r <= 1'b0;
         ovf_b_r <= 1'b0;
      end else if (load) begin
         a_r     <= '0;
         b_r     <= {{(WIDTH-1){1'b0}}, 1'b1};
         cnt_r   <= n;
         ovf_a_r <= 1'b0;
         ovf_b_r <= 1'b0;
      end else if (step && (cnt_r != '0)) begin
         a_r     <= b_r;
         b_r     <= sum_s[WIDTH-1:0];
         ovf_a_r <= ovf_b_r;
         ovf_b_r <= ovf_b_r | sum_s[WIDTH];
         cnt_r   <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         a_r     <= a_r;
         b_r     <= b_r;
         cnt_r   <= cnt_r;
         ovf_a_r <= ovf_a_r;
         ovf_b_r <= ovf_b_r;
      end
   end

   assign done = (cnt_r == '0);
   assign fib  = a_r;
   assign ovf  = ovf_a_r;

endmodule : fib_core

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters.
// A request is accepted only in IDLE (ack is a same-cycle pulse), the engine
// then iterates in RUN, and the result is held in RESP until the consumer
// takes it.
module fib_sched
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH,
   parameter int NREQ  = FIB_NREQ
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   n_in,
   output logic [NREQ-1:0]         ack,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]        rsp_fib,
   output logic                    rsp_ovf,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);

   state_t           state_r;
   logic [IDW-1:0]   ptr_r;
   logic [IDW-1:0]   id_r;
   logic             rsp_valid_r;
   logic [IDW-1:0]   rsp_id_r;
   logic [WIDTH-1:0] rsp_fib_r;
   logic             rsp_ovf_r;

   logic             grant_found_s;
   logic [IDW-1:0]   grant_idx_s;
   logic [IDW-1:0]   next_ptr_s;
   logic [WIDTH-1:0] sel_n_s;
   logic             accept_s;
   logic [NREQ-1:0]  ack_s;
   logic             core_step_s;
   logic             core_done_s;
   logic [WIDTH-1:0] core_fib_s;
   logic             core_ovf_s;
   logic             busy_s;

   // Round-robin search: first asserted request at or after ptr, wrapping.
   always_comb begin
      logic [IDW-1:0] cand;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand          = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr_r) + k) % NREQ);
         if (!grant_found_s && req[cand]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Pointer moves just past the granted requester, wrapping at NREQ.
   always_comb begin
      if (grant_idx_s == IDW'(NREQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + IDW'(1);
      end
   end

   // Operand of the requester currently winning arbitration.
   always_comb begin
      sel_n_s = n_in[int'(grant_idx_s)*WIDTH +: WIDTH];
   end

   // Accept, ack pulse, engine step and busy; all suppressed during reset so
   // requests seen in a reset cycle are ignored.
   always_comb begin
      ack_s       = '0;
      accept_s    = 1'b0;
      core_step_s = 1'b0;
      busy_s      = 1'b0;
      if (rst) begin
         ack_s       = '0;
         accept_s    = 1'b0;
         core_step_s = 1'b0;
         busy_s      = 1'b0;
      end else begin
         accept_s           = (state_r == ST_IDLE) && grant_found_s;
         core_step_s        = (state_r == ST_RUN) && !core_done_s;
         busy_s             = (state_r != ST_IDLE);
         if (accept_s) begin
            ack_s[grant_idx_s] = 1'b1;
         end else begin
            ack_s = '0;
         end
      end
   end

   fib_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (accept_s),
      .n    (sel_n_s),
      .step (core_step_s),
      .done (core_done_s),
      .fib  (core_fib_s),
      .ovf  (core_ovf_s)
   );

   // Control FSM with registered response payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         id_r        <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_fib_r   <= '0;
         rsp_ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  id_r    <= grant_idx_s;
                  ptr_r   <= next_ptr_s;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (core_done_s) begin
                  rsp_valid_r <= 1'b1;
                  rsp_id_r    <= id_r;
                  rsp_fib_r   <= core_fib_s;
                  rsp_ovf_r   <= core_ovf_s;
                  state_r     <= ST_RESP;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_s;
   assign busy      = busy_s;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_fib   = rsp_fib_r;
   assign rsp_ovf   = rsp_ovf_r;

endmodule : fib_sched

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched (WIDTH=8, NREQ=4). Inputs change and outputs
// are sampled around the falling edge; the DUT updates on the rising edge.
module tb_fib_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] n_in;
   logic [3:0]  ack;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_fib;
   logic        rsp_ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fib_sched #(.WIDTH(8), .NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .n_in      (n_in),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_fib   (rsp_fib),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      int         n;
      logic [7:0] fib;
      logic       ovf;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ack_idx(input logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   // Hold reset for two edges with the given req pattern, check reset state,
   // then release at the falling edge (req left as given).
   task automatic do_reset(input logic [3:0] reqv);
      @(negedge clk);
      rst = 1'b1;
      req = reqv;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_fib", 32'(rsp_fib), 32'd0);
      chk("rst_ovf", 32'(rsp_ovf), 32'd0);
      rst = 1'b0;
   endtask

   // One full transaction with rsp_ready=1: accept, latency, payload, return.
   task automatic txn(input int idx, input int n, input logic [7:0] ef, input logic ev);
      int cyc;
      @(negedge clk);
      req = 4'd0;
      req[idx] = 1'b1;
      n_in[idx*8 +: 8] = 8'(n);
      #1;
      chk($sformatf("ack_r%0d_n%0d", idx, n), 32'(ack), 32'(4'd1 << idx));
      @(posedge clk);
      #1;
      req = 4'd0;
      chk($sformatf("busy_run_n%0d", n), 32'(busy), 32'd1);
      cyc = 1;
      while (!rsp_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk($sformatf("latency_n%0d", n), 32'(cyc), 32'(n + 2));
      chk($sformatf("fib_n%0d", n), 32'(rsp_fib), 32'(ef));
      chk($sformatf("ovf_n%0d", n), 32'(rsp_ovf), 32'(ev));
      chk($sformatf("id_n%0d", n), 32'(rsp_id), 32'(idx));
      @(posedge clk);
      #1;
      chk($sformatf("valid_drop_n%0d", n), 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int exp_order [5];
      logic [7:0] fib4 [4];
      int k;
      int last_id;
      int cyc;
      int seen_valid;

      tbl[0] = '{idx: 0, n: 10, fib: 8'd55,  ovf: 1'b0};
      tbl[1] = '{idx: 1, n: 0,  fib: 8'd0,   ovf: 1'b0};
      tbl[2] = '{idx: 2, n: 1,  fib: 8'd1,   ovf: 1'b0};
      tbl[3] = '{idx: 3, n: 13, fib: 8'd233, ovf: 1'b0};
      tbl[4] = '{idx: 1, n: 14, fib: 8'd121, ovf: 1'b1};
      tbl[5] = '{idx: 2, n: 12, fib: 8'd144, ovf: 1'b0};

      rst = 1'b1;
      req = 4'd0;
      n_in = 32'd0;
      rsp_ready = 1'b1;

      // Reset with every request asserted: nothing may be acknowledged.
      do_reset(4'hF);
      req = 4'd0;

      // Table-driven single transactions.
      for (int i = 0; i < 6; i++) begin
         txn(tbl[i].idx, tbl[i].n, tbl[i].fib, tbl[i].ovf);
      end

      // All four requesters held high from reset: round-robin 0,1,2,3,0.
      n_in = {8'd5, 8'd4, 8'd3, 8'd2};
      fib4 = '{8'd1, 8'd2, 8'd3, 8'd5};
      exp_order = '{0, 1, 2, 3, 0};
      do_reset(4'hF);
      k = 0;
      last_id = -1;
      cyc = 0;
      while (k < 5 && cyc < 300) begin
         #1;
         if (ack != 4'd0) begin
            chk($sformatf("rr_ack%0d", k), 32'(ack_idx(ack)), 32'(exp_order[k]));
            chk($sformatf("rr_onehot%0d", k), 32'($countones(ack)), 32'd1);
            last_id = ack_idx(ack);
            k++;
         end
         if (rsp_valid) begin
            chk("rr_rsp_id", 32'(rsp_id), 32'(last_id));
            chk("rr_rsp_fib", 32'(rsp_fib), 32'(fib4[last_id & 3]));
         end
         @(negedge clk);
         cyc++;
      end
      chk("rr_ack_count", 32'(k), 32'd5);
      req = 4'd0;

      // Consumer stalls five cycles in RESP while another request waits.
      do_reset(4'd0);
      rsp_ready = 1'b0;
      n_in = 32'd0;
      n_in[15:8] = 8'd7;
      req = 4'b0010;
      #1;
      chk("stall_ack", 32'(ack), 32'b0010);
      @(posedge clk);
      #1;
      req = 4'b0001;
      cyc = 1;
      while (!rsp_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("stall_latency", 32'(cyc), 32'd9);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk($sformatf("stall_valid%0d", s), 32'(rsp_valid), 32'd1);
         chk($sformatf("stall_fib%0d", s), 32'(rsp_fib), 32'd13);
         chk($sformatf("stall_id%0d", s), 32'(rsp_id), 32'd1);
         chk($sformatf("stall_ovf%0d", s), 32'(rsp_ovf), 32'd0);
         chk($sformatf("stall_noack%0d", s), 32'(ack), 32'd0);
         chk($sformatf("stall_busy%0d", s), 32'(busy), 32'd1);
      end
      rsp_ready = 1'b1;
      req = 4'd0;
      @(posedge clk);
      #1;
      chk("stall_release_valid", 32'(rsp_valid), 32'd0);
      chk("stall_hold_fib", 32'(rsp_fib), 32'd13);
      chk("stall_hold_id", 32'(rsp_id), 32'd1);
      chk("stall_idle_busy", 32'(busy), 32'd0);

      // Reset during RUN of n=20 aborts; a later request completes normally.
      do_reset(4'd0);
      n_in = 32'd0;
      n_in[7:0] = 8'd20;
      req = 4'b0001;
      #1;
      chk("abort_ack", 32'(ack), 32'b0001);
      @(posedge clk);
      #1;
      req = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0010;
      #1;
      chk("abort_rst_ack", 32'(ack), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      req = 4'd0;
      seen_valid = 0;
      for (int s = 0; s < 30; s++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid = 1;
      end
      chk("abort_no_rsp", 32'(seen_valid), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      txn(2, 5, 8'd5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fib_sched
